// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory copy controller: default widths,
// FSM state encodings and the length clamp helper.
package mem_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // State register type; encodings kept as plain constants so older
  // blocks that compare raw state codes keep working.
  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t RD   = 3'd1;
  localparam state_t WT   = 3'd2;
  localparam state_t WR   = 3'd3;
  localparam state_t VA   = 3'd4;
  localparam state_t VW   = 3'd5;
  localparam state_t VC   = 3'd6;
  localparam state_t DONE = 3'd7;

  // Requests longer than the memory depth are cut down to the full depth.
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/mem_copy_ctrl.sv
// Copy engine: streams len words from ROM (src_base..) into RAM (dst_base..)
// under start/busy/done handshaking. With MEM_COPY_VERIFY_EN defined, a read
// back pass compares both memories and counts mismatches in err_count;
// without it the engine finishes straight after the last write and
// err_count stays 0.
module mem_copy_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_rom,
  input  logic [DW-1:0] q_rom,
  output logic [AW-1:0] a_ram,
  output logic [DW-1:0] d_ram,
  output logic          wren,
  input  logic [DW-1:0] q_ram,
  output logic [AW:0]   err_count
);

  localparam int unsigned MAX_LEN = 1 << AW;

  state_t        state;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [AW:0]   len_reg;
  logic [AW-1:0] k;
  logic [DW-1:0] data_reg;
  logic          last_word;

  // k walks 0..len-1; len_reg is never zero outside IDLE/DONE
  assign last_word = ({1'b0, k} == (len_reg - (AW+1)'(1)));

  // Main sequencer: captures the request, steps the word index and
  // latches memory read data at the point it becomes valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src_reg  <= '0;
      dst_reg  <= '0;
      len_reg  <= '0;
      k        <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_reg <= src_base;
            dst_reg <= dst_base;
            len_reg <= (AW+1)'(clamp_len(32'(len), MAX_LEN));
            k       <= '0;
            state   <= (len == '0) ? DONE : RD;
          end
        end
        RD: state <= WT;
        WT: begin
          data_reg <= q_rom;
          state    <= WR;
        end
        WR: begin
          if (last_word) begin
            k <= '0;
`ifdef MEM_COPY_VERIFY_EN
            state <= VA;
`else
            state <= DONE;
`endif
          end else begin
            k     <= k + 1'b1;
            state <= RD;
          end
        end
`ifdef MEM_COPY_VERIFY_EN
        VA: state <= VW;
        VW: begin
          data_reg <= q_rom;
          state    <= VC;
        end
        VC: begin
          if (last_word) begin
            state <= DONE;
          end else begin
            k     <= k + 1'b1;
            state <= VA;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPY_VERIFY_EN
  logic [DW-1:0] ram_word;
  logic [AW:0]   err_reg;

  // Verify datapath: hold the RAM word next to the ROM word and count
  // differences, saturating at the memory depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_word <= '0;
      err_reg  <= '0;
    end else if (state == IDLE && start) begin
      err_reg <= '0;
    end else if (state == VW) begin
      ram_word <= q_ram;
    end else if (state == VC && data_reg != ram_word &&
                 err_reg != (AW+1)'(MAX_LEN)) begin
      err_reg <= err_reg + 1'b1;
    end
  end

  assign err_count = err_reg;
`else
  logic unused_q_ram;

  assign unused_q_ram = ^q_ram;
  assign err_count    = '0;
`endif

  // Outputs decode straight from state so reset clears them at once
  assign busy  = (state != IDLE) && (state != DONE);
  assign done  = (state == DONE);
  assign wren  = (state == WR);
  assign a_rom = src_reg + k;
  assign a_ram = dst_reg + k;
  assign d_ram = data_reg;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl with behavioural synchronous ROM/RAM models.
// Expected writes are queued when each operation is launched and popped by
// a write monitor; latency, handshake, RAM contents and err_count are checked
// per scenario. Define MEM_COPY_VERIFY_EN for both bench and RTL to exercise
// the verify pass.
module tb_mem_copy_ctrl;

`ifdef MEM_COPY_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       start;
  logic [4:0] src_base;
  logic [4:0] dst_base;
  logic [5:0] len;
  logic       busy;
  logic       done;
  logic [4:0] a_rom;
  logic [7:0] q_rom;
  logic [4:0] a_ram;
  logic [7:0] d_ram;
  logic       wren;
  logic [7:0] q_ram;
  logic [5:0] err_count;

  logic [7:0] rom [32];
  logic [7:0] ram [32];
  bit         poke;
  logic [4:0] poke_addr;

  typedef struct packed {
    logic [4:0] rom_addr;
    logic [4:0] ram_addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  checks;
  int  errors;
  int  done_seen;

  mem_copy_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .a_rom     (a_rom),
    .q_rom     (q_rom),
    .a_ram     (a_ram),
    .d_ram     (d_ram),
    .wren      (wren),
    .q_ram     (q_ram),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    for (int a = 0; a < 32; a++) begin
      rom[a] = 8'(a + 1);
      ram[a] = 8'h00;
    end
  end

  // Synchronous ROM model
  always @(posedge clock) q_rom <= rom[a_rom];

  // Synchronous RAM model with a bench-side corruption port
  always @(posedge clock) begin
    if (wren) ram[a_ram] <= d_ram;
    else if (poke) ram[poke_addr] <= 8'hFF;
    q_ram <= ram[a_ram];
  end

  // Write monitor: every RAM write must match the next queued expectation
  always @(negedge clock) begin
    if (wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write a_ram=%0d d_ram=%0h", a_ram, d_ram);
      end else begin
        exp_w = exp_q.pop_front();
        if ({a_rom, a_ram, d_ram} !== exp_w) begin
          errors++;
          $display("[TB] FAIL write got a_rom=%0d a_ram=%0d d_ram=%0h exp a_rom=%0d a_ram=%0d d_ram=%0h",
                   a_rom, a_ram, d_ram, exp_w.rom_addr, exp_w.ram_addr, exp_w.data);
        end
      end
    end
    if (done) done_seen++;
  end

  task automatic push_expected(input logic [4:0] src, input logic [4:0] dst, input int nn);
    logic [4:0] ra;
    logic [4:0] wa;
    for (int i = 0; i < nn; i++) begin
      ra = src + 5'(i);
      wa = dst + 5'(i);
      exp_q.push_back('{rom_addr: ra, ram_addr: wa, data: rom[ra]});
    end
  endtask

  // One full operation: launch, watch busy/done timing, then check results
  task automatic run_copy(input logic [4:0] src, input logic [4:0] dst, input logic [5:0] n,
                          input bit corrupt, input bit start_again, input string name);
    int         nn;
    int         exp_lat;
    int         lat;
    bit         seen;
    logic [4:0] wa;
    logic [7:0] exp_d;
    logic [5:0] exp_err;
    nn      = (n > 6'd32) ? 32 : int'(n);
    exp_lat = VERIFY_ON ? 6 * nn + 1 : 3 * nn + 1;
    exp_err = (corrupt && VERIFY_ON && nn > 0) ? 6'd1 : 6'd0;
    push_expected(src, dst, nn);
    done_seen = 0;
    @(negedge clock);
    src_base = src;
    dst_base = dst;
    len      = n;
    start    = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < exp_lat + 20) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        src_base = 5'd13;
        dst_base = 5'd27;
        len      = 6'd5;
        checks++;
        if (busy !== (nn > 0)) begin
          errors++;
          $display("[TB] FAIL %s_busy_rise got %0b exp %0b", name, busy, (nn > 0));
        end
      end
      if (start_again && lat == 5) begin
        src_base = 5'd17;
        dst_base = 5'd0;
        len      = 6'd3;
        start    = 1'b1;
      end
      if (start_again && lat == 6) start = 1'b0;
      if (corrupt && lat == 31) begin
        poke_addr = 5'd7;
        poke      = 1'b1;
      end
      if (corrupt && lat == 32) poke = 1'b0;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL %s_latency got %0d (seen=%0b) exp %0d", name, lat, seen, exp_lat);
    end
    checks++;
    if (err_count !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s_err_count got %0d exp %0d", name, err_count, exp_err);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_width got done=%0b busy=%0b exp 0 0", name, done, busy);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (done_seen != 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_pulses got done=%0d pending=%0d exp 1 0", name, done_seen, exp_q.size());
    end
    for (int i = 0; i < nn; i++) begin
      wa    = dst + 5'(i);
      exp_d = (corrupt && wa == 5'd7) ? 8'hFF : rom[src + 5'(i)];
      checks++;
      if (ram[wa] !== exp_d) begin
        errors++;
        $display("[TB] FAIL %s_ram[%0d] got %0h exp %0h", name, wa, ram[wa], exp_d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    len = '0;
    poke = 1'b0;
    poke_addr = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, wren, a_rom, a_ram, d_ram, err_count} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_state got busy=%0b done=%0b wren=%0b a_rom=%0d a_ram=%0d d_ram=%0h err=%0d exp all 0",
               busy, done, wren, a_rom, a_ram, d_ram, err_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_copy();
    run_copy(5'd0, 5'd0, 6'd32, 1'b0, 1'b0, "full");
  endtask

  task automatic test_wrap();
    run_copy(5'd30, 5'd5, 6'd4, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_len_zero();
    run_copy(5'd3, 5'd3, 6'd0, 1'b0, 1'b0, "len0");
  endtask

  task automatic test_clamp();
    run_copy(5'd3, 5'd9, 6'd63, 1'b0, 1'b0, "clamp");
  endtask

  task automatic test_back_to_back();
    run_copy(5'd2, 5'd20, 6'd10, 1'b0, 1'b1, "restart");
  endtask

  task automatic test_verify_corrupt();
    run_copy(5'd0, 5'd0, 6'd32, 1'b1, 1'b0, "corrupt");
  endtask

  task automatic test_reset_mid();
    push_expected(5'd0, 5'd0, 32);
    @(negedge clock);
    src_base = 5'd0;
    dst_base = 5'd0;
    len      = 6'd32;
    start    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async got wren=%0b busy=%0b exp 0 0", wren, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    run_copy(5'd4, 5'd12, 6'd2, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_seen = 0;
    test_reset();
    test_full_copy();
    test_wrap();
    test_len_zero();
    test_clamp();
    test_back_to_back();
    test_verify_corrupt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_ctrl.md
Name: mem_copy_ctrl

Overview:
Sequencer that copies a block of words from the 32x8 ROM into the 32x8 RAM, then optionally reads both back and counts mismatches. It replaces the hard-wired ROM/RAM test FSM with a start/busy/done controlled engine. It sits between a host FSM or processor control unit and the two synchronous memories. Both memories are clocked by clock, and all memory control signals come from this block.

Parameters:
AW, 5, address width; memory depth is 2**AW.
DW, 8, data width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
src_base  in  AW  first ROM address; captured on start.
dst_base  in  AW  first RAM address; captured on start.
len  in  AW+1  word count, 0..2**AW; values above 2**AW are clamped to 2**AW.
busy  out  1  operation in progress.
done  out  1  single-cycle completion pulse.
a_rom  out  AW  ROM address.
q_rom  in  DW  ROM data, valid one cycle after a_rom is registered.
a_ram  out  AW  RAM address.
d_ram  out  DW  RAM write data.
wren  out  1  RAM write enable.
q_ram  in  DW  RAM read data, one-cycle latency.
err_count  out  AW+1  number of verify mismatches.

Behaviour:
- Moore FSM. Outputs are functions of the state and internal registers only.
- Reset values: state=IDLE, busy=0, done=0, wren=0, a_rom=0, a_ram=0, d_ram=0, err_count=0, k=0.
- States and transitions:
  - IDLE: on start=1, capture src/dst/len (clamped) and set k=0. If len=0, go to DONE; otherwise go to RD. err_count is cleared on accepted start.
  - RD: a_rom=src+k. Next state is WT.
  - WT: capture q_rom into the data register. Next state is WR.
  - WR: a_ram=dst+k, d_ram=data register, wren=1 for exactly this cycle. If k=len-1, set k=0 and go to VA (VERIFY_EN) or DONE. Otherwise k++ and go to RD.
  - VA: a_rom=src+k, a_ram=dst+k, wren=0. Next state is VW.
  - VW: capture q_rom and q_ram. Next state is VC.
  - VC: if the captured words differ, err_count++ (saturating at 2**AW). If k=len-1, go to DONE; otherwise k++ and go to VA.
  - DONE: done=1 for one cycle, busy=0. Next state is IDLE.
- busy=1 in every state except IDLE and DONE, and it rises in the cycle after start is accepted.
- Latency: start edge to done high is 3*len+1 cycles without verify and 6*len+1 cycles with verify. For len=0 it is 1 cycle.
- Address arithmetic is modulo 2**AW, so src+k and dst+k wrap (for example src=30, len=4 reads 30, 31, 0, 1).
- start while busy or in DONE: ignored, with no queuing.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and wren drops asynchronously. A partially written RAM is not restored.
- Input changes on src_base, dst_base and len after capture have no effect.

Optional Feature:
- Macro: MEM_COPY_VERIFY_EN.
- Defined: the VA/VW/VC verify pass runs after the copy, and err_count is live.
- Undefined: WR goes straight to DONE after the last word, the VA/VW/VC states are absent, and err_count is tied to 0.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum and the encoding constants IDLE, RD, WT, WR, VA, VW, VC, DONE;
  - default ADDR_W=5 and DATA_W=8;
  - a helper function for the clamped length.
- No sub-module: the FSM, counter and datapath registers fit in a single module.

Test Plan:
- ROM[a]=a+1 for all a; start with src=0, dst=0, len=32 -> RAM[a]=a+1 for all a, done pulses 97 cycles after the start edge (193 with verify), err_count=0.
- src=30, dst=5, len=4 -> RAM[5..8]={31,32,1,2}, and a_rom sequence 30, 31, 0, 1 is observed.
- len=0 -> done pulses 1 cycle after start, wren is never asserted, busy stays 0.
- Force RAM[7] to 0xFF via a testbench write between WR of k=7 and verify (VERIFY_EN, src=dst=0, len=32) -> err_count=1 at done.
- Assert reset at cycle 20 of a len=32 copy -> wren=0 and busy=0 immediately. A new start with len=2 then completes normally in 7 cycles.
- Pulse start again while busy -> no restart, and the original operation completes with a single done pulse.
